smi_frame_arbiter_x4: RTL and testbench



---
 rtl/smi_arb_pkg.sv | 25 ++
 rtl/smi_arb_priority_pick.sv | 27 ++
 rtl/smi_frame_arbiter_x4.sv | 171 +++++++++++++++++
 tb/tb_smi_frame_arbiter_x4.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/smi_arb_pkg.sv
// Shared types and constants for the four-port SMI frame arbiter.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package smi_arb_pkg;

  localparam int         SMI_ARB_PORTS = 4;
  localparam logic [7:0] SMI_EOFC_NONE = 8'h00;

  // IDLE arbitrates; LOCKED forwards flits from the granted port until end of frame.
  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arbState_t;

  // Index of the set bit in a one-hot port vector (0 when the vector is empty).
  function automatic logic [1:0] oneHotToIdx(input logic [SMI_ARB_PORTS-1:0] oneHot);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < SMI_ARB_PORTS; i++) begin
      if (oneHot[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/smi_arb_priority_pick.sv
// Picks one requester out of four, searching upward (with wrap) from a start pointer.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the request vector and pointer.
module smi_arb_priority_pick
  import smi_arb_pkg::*;
(
  input  logic [SMI_ARB_PORTS-1:0] req,
  input  logic [1:0]               ptr,
  output logic [SMI_ARB_PORTS-1:0] winner
);

  logic [1:0] idx;

  // Walk offsets from farthest to nearest so the requester closest to ptr is the last write.
  always_comb begin
    winner = '0;
    idx    = 2'd0;
    for (int i = SMI_ARB_PORTS - 1; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (req[idx]) begin
        winner      = '0;
        winner[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/smi_frame_arbiter_x4.sv
// Frame-level arbiter merging four SMI input streams onto one registered SMI output; SMI_ARB_ROUND_ROBIN_EN selects rotating priority (default fixed, port 0 highest).
// Latency: request to grant 1 cycle, accepted flit to smiOutReady 1 cycle; one idle cycle between frames.
// Backpressure: only the granted port can see Stop low, and only while the output register is empty or draining.
module smi_frame_arbiter_x4
  import smi_arb_pkg::*;
#(
  parameter int FlitWidth = 16
) (
  input  logic                   clk,
  input  logic                   srst,

  input  logic                   smiIn0Ready,
  input  logic [7:0]             smiIn0Eofc,
  input  logic [FlitWidth*8-1:0] smiIn0Data,
  output logic                   smiIn0Stop,

  input  logic                   smiIn1Ready,
  input  logic [7:0]             smiIn1Eofc,
  input  logic [FlitWidth*8-1:0] smiIn1Data,
  output logic                   smiIn1Stop,

  input  logic                   smiIn2Ready,
  input  logic [7:0]             smiIn2Eofc,
  input  logic [FlitWidth*8-1:0] smiIn2Data,
  output logic                   smiIn2Stop,

  input  logic                   smiIn3Ready,
  input  logic [7:0]             smiIn3Eofc,
  input  logic [FlitWidth*8-1:0] smiIn3Data,
  output logic                   smiIn3Stop,

  output logic                   smiOutReady,
  output logic [7:0]             smiOutEofc,
  output logic [FlitWidth*8-1:0] smiOutData,
  input  logic                   smiOutStop,

  output logic [3:0]             smiArbGrant
);

  typedef struct packed {
    logic [7:0]             eofc;
    logic [FlitWidth*8-1:0] data;
  } smiFlit_t;

  // Per-port views of the requester links.
  logic [SMI_ARB_PORTS-1:0] reqVec;
  smiFlit_t                 inFlit [SMI_ARB_PORTS];
  logic [SMI_ARB_PORTS-1:0] stopVec;

  // Arbitration state.
  arbState_t                stateQ;
  arbState_t                stateD;
  logic [SMI_ARB_PORTS-1:0] grantQ;
  logic [SMI_ARB_PORTS-1:0] grantD;
  logic [1:0]               grantIdx;
  logic [1:0]               pickPtr;
  logic [SMI_ARB_PORTS-1:0] winner;

  // Output stage.
  smiFlit_t                 outFlitQ;
  logic                     outValidQ;
  smiFlit_t                 selFlit;
  logic                     canLoad;
  logic                     grantedReady;
  logic                     accept;
  logic                     lastAccept;

  assign reqVec    = {smiIn3Ready, smiIn2Ready, smiIn1Ready, smiIn0Ready};
  assign inFlit[0] = '{eofc: smiIn0Eofc, data: smiIn0Data};
  assign inFlit[1] = '{eofc: smiIn1Eofc, data: smiIn1Data};
  assign inFlit[2] = '{eofc: smiIn2Eofc, data: smiIn2Data};
  assign inFlit[3] = '{eofc: smiIn3Eofc, data: smiIn3Data};

  assign grantIdx     = oneHotToIdx(grantQ);
  assign selFlit      = inFlit[grantIdx];
  // The single output slot can take a flit when it is empty or emptying this cycle.
  assign canLoad      = !outValidQ || !smiOutStop;
  assign grantedReady = |(grantQ & reqVec);
  assign accept       = (stateQ == LOCKED) && grantedReady && canLoad;
  assign lastAccept   = accept && (selFlit.eofc != SMI_EOFC_NONE);

  smi_arb_priority_pick uPick (
    .req    (reqVec),
    .ptr    (pickPtr),
    .winner (winner)
  );

`ifdef SMI_ARB_ROUND_ROBIN_EN
  logic [1:0] ptrQ;

  // Rotate the search start to just past the port whose frame has just finished.
  always_ff @(posedge clk) begin
    if (srst) begin
      ptrQ <= 2'd0;
    end else if (lastAccept) begin
      ptrQ <= grantIdx + 2'd1;
    end
  end

  assign pickPtr = ptrQ;
`else
  assign pickPtr = 2'd0;
`endif

  // Next state and grant: lock onto a winner from IDLE, release after the last flit is taken.
  always_comb begin
    stateD = stateQ;
    grantD = grantQ;
    case (stateQ)
      IDLE: begin
        if (|reqVec) begin
          grantD = winner;
          stateD = LOCKED;
        end
      end
      LOCKED: begin
        if (lastAccept) begin
          grantD = '0;
          stateD = IDLE;
        end
      end
      default: begin
        grantD = '0;
        stateD = IDLE;
      end
    endcase
  end

  // State and grant registers.
  always_ff @(posedge clk) begin
    if (srst) begin
      stateQ <= IDLE;
      grantQ <= '0;
    end else begin
      stateQ <= stateD;
      grantQ <= grantD;
    end
  end

  // Output flit register: load on accept, otherwise empty out once the sink takes it.
  always_ff @(posedge clk) begin
    if (srst) begin
      outValidQ <= 1'b0;
      outFlitQ  <= '0;
    end else if (accept) begin
      outValidQ <= 1'b1;
      outFlitQ  <= selFlit;
    end else if (outValidQ && !smiOutStop) begin
      outValidQ <= 1'b0;
    end
  end

  // Everyone is stopped except the granted port while locked and out of reset.
  always_comb begin
    stopVec = '1;
    if (!srst && (stateQ == LOCKED)) begin
      stopVec[grantIdx] = !canLoad;
    end
  end

  assign smiIn0Stop  = stopVec[0];
  assign smiIn1Stop  = stopVec[1];
  assign smiIn2Stop  = stopVec[2];
  assign smiIn3Stop  = stopVec[3];

  assign smiOutReady = outValidQ;
  assign smiOutEofc  = outFlitQ.eofc;
  assign smiOutData  = outFlitQ.data;
  assign smiArbGrant = grantQ;

endmodule

// File: tb/tb_smi_frame_arbiter_x4.sv
`timescale 1ns/1ps
module tb_smi_frame_arbiter_x4;

  localparam int FW = 16;
  localparam int DW = FW * 8;

  typedef struct packed {
    logic [7:0]    eofc;
    logic [DW-1:0] data;
  } flit_t;

  logic          clk;
  logic          srst;
  logic          inReady [4];
  logic [7:0]    inEofc  [4];
  logic [DW-1:0] inData  [4];
  logic          inStop  [4];
  logic          smiOutReady;
  logic [7:0]    smiOutEofc;
  logic [DW-1:0] smiOutData;
  logic          smiOutStop;
  logic [3:0]    smiArbGrant;

  smi_frame_arbiter_x4 #(.FlitWidth(FW)) dut (
    .clk         (clk),
    .srst        (srst),
    .smiIn0Ready (inReady[0]), .smiIn0Eofc (inEofc[0]), .smiIn0Data (inData[0]), .smiIn0Stop (inStop[0]),
    .smiIn1Ready (inReady[1]), .smiIn1Eofc (inEofc[1]), .smiIn1Data (inData[1]), .smiIn1Stop (inStop[1]),
    .smiIn2Ready (inReady[2]), .smiIn2Eofc (inEofc[2]), .smiIn2Data (inData[2]), .smiIn2Stop (inStop[2]),
    .smiIn3Ready (inReady[3]), .smiIn3Eofc (inEofc[3]), .smiIn3Data (inData[3]), .smiIn3Stop (inStop[3]),
    .smiOutReady (smiOutReady),
    .smiOutEofc  (smiOutEofc),
    .smiOutData  (smiOutData),
    .smiOutStop  (smiOutStop),
    .smiArbGrant (smiArbGrant)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  // Bench state shared between the engine and the scenario sequencer.
  int     tests = 0;
  int     fails = 0;
  int     cyc   = 0;
  event   tick;
  logic   wantRst  = 1'b1;
  logic   wantStop = 1'b0;
  int     gap [4];
  int     xferCnt [4];
  flit_t  srcQ [4][$];
  flit_t  expQ [$];
  int     pickLog [$];
  int     outXferCyc [$];
  int     modelLock = -1;
  int     modelPtr  = 0;
  logic   modelFull = 1'b0;

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] mkData(input int p, input int f, input int i);
    logic [DW-1:0] d;
    d = '0;
    d[7:0]       = 8'(i);
    d[15:8]      = 8'(f);
    d[23:16]     = 8'(p);
    d[DW-1 -: 8] = 8'hC3 ^ 8'(p);
    return d;
  endfunction

  task automatic pushFrame(input int p, input int f, input int n, input logic [7:0] lastEofc);
    flit_t fl;
    for (int i = 0; i < n; i++) begin
      fl.eofc = (i == n - 1) ? lastEofc : 8'h00;
      fl.data = mkData(p, f, i);
      srcQ[p].push_back(fl);
    end
  endtask

  // First requesting port found searching upward from ptr with wrap.
  function automatic int pickModel(input logic [3:0] r, input int ptr);
    for (int k = 0; k < 4; k++) begin
      if (r[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  function automatic bit benchIdle();
    bit e;
    e = (modelLock < 0) && !modelFull && (expQ.size() == 0);
    for (int p = 0; p < 4; p++) if (srcQ[p].size() != 0) e = 0;
    return e;
  endfunction

  // Engine: applies last cycle's handshakes to the model, checks DUT outputs, drives, samples.
  initial begin : engine
    logic [3:0]    smpReq;
    logic [3:0]    smpInXfer;
    logic          smpOutXfer;
    logic          smpOutVld;
    logic          smpOutStop;
    logic [7:0]    smpOutEofc;
    logic [DW-1:0] smpOutData;
    logic          smpRst;
    bit            havePrev;
    bit            anyIn;
    int            w;
    flit_t         f;
    logic [3:0]    expGrant;
    logic          expStop;

    havePrev = 0;
    srst = 1'b1;
    smiOutStop = 1'b0;
    for (int p = 0; p < 4; p++) begin
      inReady[p] = 1'b0; inEofc[p] = 8'h00; inData[p] = '0; gap[p] = 0; xferCnt[p] = 0;
    end
    forever begin
      @(negedge clk);
      cyc++;
      if (havePrev) begin
        if (smpRst) begin
          modelLock = -1; modelPtr = 0; modelFull = 1'b0; expQ.delete();
        end else begin
          if (smpOutXfer) begin
            outXferCyc.push_back(cyc);
            if (expQ.size() == 0) begin
              tests++; fails++;
              $display("FAIL extraFlit: got eofc %h data %h, required no flit (cycle %0d)", smpOutEofc, smpOutData, cyc);
            end else begin
              f = expQ.pop_front();
              chk("outEofc", smpOutEofc, f.eofc);
              chk("outData", smpOutData, f.data);
            end
          end
          anyIn = 0;
          if (modelLock < 0) begin
            w = pickModel(smpReq, modelPtr);
            if (w >= 0) begin
              modelLock = w;
              pickLog.push_back(w);
              for (int i = 0; i < srcQ[w].size(); i++) begin
                expQ.push_back(srcQ[w][i]);
                if (srcQ[w][i].eofc != 8'h00) break;
              end
            end
          end else begin
            for (int p = 0; p < 4; p++) begin
              if (smpInXfer[p]) begin
                anyIn = 1;
                if (p != modelLock) begin
                  tests++; fails++;
                  $display("FAIL acceptPort: got accept on port %0d, required only port %0d (cycle %0d)", p, modelLock, cyc);
                end else begin
                  f = srcQ[p].pop_front();
                  xferCnt[p]++;
                  if (f.eofc != 8'h00) begin
                    modelLock = -1;
`ifdef SMI_ARB_ROUND_ROBIN_EN
                    modelPtr = (p + 1) % 4;
`endif
                  end
                end
              end
            end
          end
          if (anyIn) modelFull = 1'b1;
          else if (smpOutXfer) modelFull = 1'b0;
        end
        expGrant = (modelLock < 0) ? 4'b0000 : 4'(1 << modelLock);
        chk("grant", smiArbGrant, expGrant);
        chk("outReady", smiOutReady, modelFull);
        if (!smpRst && smpOutVld && smpOutStop) begin
          chk("stallEofc", smiOutEofc, smpOutEofc);
          chk("stallData", smiOutData, smpOutData);
        end
      end
      srst = wantRst;
      smiOutStop = wantStop;
      for (int p = 0; p < 4; p++) begin
        if (wantRst) srcQ[p].delete();
        if (gap[p] > 0) begin
          inReady[p] = 1'b0;
          gap[p]--;
        end else if (srcQ[p].size() > 0) begin
          inReady[p] = 1'b1;
          inEofc[p]  = srcQ[p][0].eofc;
          inData[p]  = srcQ[p][0].data;
        end else begin
          inReady[p] = 1'b0;
        end
      end
      #1;
      for (int p = 0; p < 4; p++) begin
        smpReq[p]    = inReady[p];
        smpInXfer[p] = inReady[p] && !inStop[p];
        expStop      = (srst || modelLock != p) ? 1'b1 : (modelFull && smiOutStop);
        chk("inStop", inStop[p], expStop);
      end
      smpOutXfer = smiOutReady && !smiOutStop && !srst;
      smpOutVld  = smiOutReady;
      smpOutStop = smiOutStop;
      smpOutEofc = smiOutEofc;
      smpOutData = smiOutData;
      smpRst     = srst;
      havePrev   = 1;
      -> tick;
    end
  end

  task automatic waitIdle(input int budget, input string name);
    int k;
    k = 0;
    while (!benchIdle() && k < budget) begin
      @(tick);
      k++;
    end
    chk(name, 1'(k < budget), 1'b1);
  endtask

  task automatic waitOutReady(input int budget, input string name);
    int k;
    k = 0;
    while (smiOutReady !== 1'b1 && k < budget) begin
      @(tick);
      k++;
    end
    chk(name, 1'(k < budget), 1'b1);
  endtask

  // Scenario sequencer.
  initial begin : sequencer
    int ord [4];
    int base;
    int k;

    repeat (3) @(tick);
    chk("rstOutReady", smiOutReady, 1'b0);
    chk("rstOutEofc",  smiOutEofc,  8'h00);
    chk("rstOutData",  smiOutData,  '0);
    chk("rstGrant",    smiArbGrant, 4'b0000);
    for (int p = 0; p < 4; p++) chk("rstStop", inStop[p], 1'b1);
    wantRst = 1'b0;
    repeat (2) @(tick);

    // Four simultaneous 2-flit frames, twice: 0,1,2,3 from reset both ways.
    ord = '{0, 1, 2, 3};
    for (int r = 0; r < 2; r++) begin
      pickLog.delete();
      for (int p = 0; p < 4; p++) pushFrame(p, 10 + r, 2, 8'h20 + 8'(p));
      waitIdle(200, "allFourDone");
      chk("allFourCount", pickLog.size(), 4);
      for (int i = 0; i < 4 && i < pickLog.size(); i++) chk("allFourOrder", pickLog[i], ord[i]);
    end

    // Port 0 re-requests immediately while port 1 waits.
    pickLog.delete();
    pushFrame(0, 20, 2, 8'h01);
    pushFrame(0, 21, 2, 8'h01);
    pushFrame(1, 20, 2, 8'h01);
    waitIdle(200, "reWinDone");
`ifdef SMI_ARB_ROUND_ROBIN_EN
    ord = '{0, 1, 0, 0};
`else
    ord = '{0, 0, 1, 0};
`endif
    chk("reWinCount", pickLog.size(), 3);
    for (int i = 0; i < 3 && i < pickLog.size(); i++) chk("reWinOrder", pickLog[i], ord[i]);

    // Single request from port 2, exact latencies.
    pushFrame(2, 1, 3, 8'h10);
    @(tick);
    chk("t1GrantBefore", smiArbGrant, 4'b0000);
    @(tick);
    chk("t1Grant", smiArbGrant, 4'b0100);
    chk("t1OutEmpty", smiOutReady, 1'b0);
    @(tick);
    chk("t1Flit0Vld",  smiOutReady, 1'b1);
    chk("t1Flit0Data", smiOutData, mkData(2, 1, 0));
    chk("t1Flit0Eofc", smiOutEofc, 8'h00);
    @(tick);
    chk("t1Flit1Data", smiOutData, mkData(2, 1, 1));
    @(tick);
    chk("t1Flit2Data", smiOutData, mkData(2, 1, 2));
    chk("t1Flit2Eofc", smiOutEofc, 8'h10);
    chk("t1GrantEnd",  smiArbGrant, 4'b0000);
    waitIdle(50, "t1Done");

    // Output stalled for 5 cycles mid-frame.
    pushFrame(1, 4, 4, 8'h02);
    waitOutReady(50, "t4Start");
    wantStop = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(tick);
      chk("t4StallVld",  smiOutReady, 1'b1);
      chk("t4StallData", smiOutData, mkData(1, 4, 1));
      chk("t4StallEofc", smiOutEofc, 8'h00);
      chk("t4GrantStop", inStop[1], 1'b1);
    end
    wantStop = 1'b0;
    waitIdle(50, "t4Done");

    // Granted port pauses mid-frame while port 1 requests.
    pickLog.delete();
    pushFrame(0, 5, 4, 8'h03);
    k = 0;
    while (smiArbGrant !== 4'b0001 && k < 50) begin
      @(tick);
      k++;
    end
    chk("t5Granted", 1'(k < 50), 1'b1);
    gap[0] = 3;
    pushFrame(1, 5, 2, 8'h03);
    for (int i = 0; i < 3; i++) begin
      @(tick);
      chk("t5GrantHeld", smiArbGrant, 4'b0001);
      chk("t5Port1Stop", inStop[1], 1'b1);
    end
    waitIdle(100, "t5Done");
    chk("t5Count", pickLog.size(), 2);
    if (pickLog.size() == 2) begin
      chk("t5First",  pickLog[0], 0);
      chk("t5Second", pickLog[1], 1);
    end

    // Reset after two flits of a four-flit frame, then a clean frame from port 3.
    base = xferCnt[2];
    pushFrame(2, 6, 4, 8'h05);
    k = 0;
    while (xferCnt[2] < base + 2 && k < 50) begin
      @(tick);
      k++;
    end
    chk("t6TwoFlits", 1'(k < 50), 1'b1);
    wantRst = 1'b1;
    @(tick);
    wantRst = 1'b0;
    @(tick);
    chk("t6RstOutReady", smiOutReady, 1'b0);
    chk("t6RstOutEofc",  smiOutEofc,  8'h00);
    chk("t6RstOutData",  smiOutData,  '0);
    chk("t6RstGrant",    smiArbGrant, 4'b0000);
    chk("t6RstStop2",    inStop[2],   1'b1);
    for (int i = 0; i < 3; i++) begin
      @(tick);
      chk("t6NoFlit", smiOutReady, 1'b0);
    end
    base = xferCnt[3];
    pushFrame(3, 7, 2, 8'h06);
    waitIdle(50, "t6Done");
    chk("t6Port3Flits", xferCnt[3] - base, 2);

    // Back-to-back single-flit frames from port 0 only.
    outXferCyc.delete();
    for (int i = 0; i < 4; i++) pushFrame(0, 30 + i, 1, 8'h04);
    waitIdle(100, "t7Done");
    chk("t7Count", outXferCyc.size(), 4);
    for (int i = 1; i < 4 && i < outXferCyc.size(); i++)
      chk("t7Spacing", outXferCyc[i] - outXferCyc[i-1], 2);

    repeat (3) @(tick);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
